mmio_store_responder: RTL

MMIO_STORE_RESPONDER -- requirements
Module: mmio_store_responder

---
 rtl/mmio_store_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mmio_store_responder.sv
// rtl/mmio_store_responder.sv - MMIO store decoder driving a hex display, a log FIFO and an overflow counter.
// Optional: define MMIO_LEADING_ZERO_BLANK_EN to blank leading-zero digits.
module mmio_store_responder #(
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwriteM,
  input  logic [31:0] aluoutM,
  input  logic [31:0] writedataM,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_data,
  output logic [7:0]  overflow_cnt,
  output logic [6:0]  segment0,
  output logic [6:0]  segment1,
  output logic [6:0]  segment2,
  output logic [6:0]  segment3,
  output logic [6:0]  segment4,
  output logic [6:0]  segment5
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  logic [23:0]   disp_q, disp_d;
  logic [7:0]    ovf_q, ovf_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [6:0]    seg_q [6];
  logic [6:0]    seg_d [6];

  logic [7:0] offset;
  logic       mmio_hit, wr_disp, wr_log, wr_clr;
  logic       fifo_full, do_pop, do_push, do_drop;

  // Byte-lane bits of the address are masked so any byte within a word selects it.
  assign offset   = aluoutM[7:0] & 8'hFC;
  assign mmio_hit = memwriteM && (aluoutM[31:8] == MMIO_BASE[31:8]);
  assign wr_disp  = mmio_hit && (offset == 8'h00);
  assign wr_log   = mmio_hit && (offset == 8'h04);
  assign wr_clr   = mmio_hit && (offset == 8'h08);

  assign fifo_full = (count_q == FULL_CNT);
  assign do_pop    = (count_q != '0) && log_ready;
  // A pop frees a slot at the same edge, so a full FIFO still accepts the push.
  assign do_push   = wr_log && (!fifo_full || do_pop);
  assign do_drop   = wr_log && fifo_full && !do_pop;

  always_comb begin
    disp_d   = wr_disp ? writedataM[23:0] : disp_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (wr_clr) begin
      ovf_d = '0;
    end else if (do_drop && (ovf_q != 8'hFF)) begin
      ovf_d = ovf_q + 1'b1;
    end
  end

  always_comb begin
    logic upper_zero;
    upper_zero = 1'b1;
    for (int k = 0; k < 6; k++) begin
      seg_d[k] = SEG_BLANK;
    end
    for (int k = 5; k >= 0; k--) begin
      upper_zero = upper_zero && (disp_d[4*k +: 4] == 4'h0);
`ifdef MMIO_LEADING_ZERO_BLANK_EN
      seg_d[k] = (upper_zero && (k != 0)) ? SEG_BLANK : hex_to_seg(disp_d[4*k +: 4]);
`else
      seg_d[k] = hex_to_seg(disp_d[4*k +: 4]);
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q   <= '0;
      ovf_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < 6; k++) begin
`ifdef MMIO_LEADING_ZERO_BLANK_EN
        seg_q[k] <= (k == 0) ? SEG_ZERO : SEG_BLANK;
`else
        seg_q[k] <= SEG_ZERO;
`endif
      end
    end else begin
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int k = 0; k < 6; k++) begin
        seg_q[k] <= seg_d[k];
      end
    end
  end

  // Storage needs no reset: the count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= writedataM;
    end
  end

  assign log_valid    = (count_q != '0);
  assign log_data     = log_valid ? mem_q[rd_ptr_q] : 32'h0;
  assign overflow_cnt = ovf_q;
  assign segment0     = seg_q[0];
  assign segment1     = seg_q[1];
  assign segment2     = seg_q[2];
  assign segment3     = seg_q[3];
  assign segment4     = seg_q[4];
  assign segment5     = seg_q[5];

endmodule
